// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the requesting channels / cache controller and the
// mem_req_arbiter. "master" is the system side (channels plus cache
// controller); "slave" is the arbiter itself.
interface mem_req_arbiter_if #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // Channel request side
    logic [NUM_CH-1:0]        ch_req_valid;
    logic [NUM_CH-1:0]        ch_req_ready;
    logic [NUM_CH-1:0]        ch_req_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
    logic [NUM_CH*DATA_W-1:0] ch_req_data;
    // Channel response side
    logic [NUM_CH-1:0]        ch_rsp_valid;
    logic [DATA_W-1:0]        ch_rsp_data;
    // Cache controller port
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_wr;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [DATA_W-1:0]        mem_req_data;
    logic                     mem_rsp_valid;
    logic [DATA_W-1:0]        mem_rsp_data;
    // Status
    logic [CNT_W-1:0]         outstanding;
    logic                     rsp_err;

    modport master (
        output ch_req_valid, ch_req_wr, ch_req_addr, ch_req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ch_req_ready, ch_rsp_valid, ch_rsp_data,
        input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_data,
        input  outstanding, rsp_err
    );

    modport slave (
        input  ch_req_valid, ch_req_wr, ch_req_addr, ch_req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ch_req_ready, ch_rsp_valid, ch_rsp_data,
        output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_data,
        output outstanding, rsp_err
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging NUM_CH requesters onto one cache controller
// port. A single registered output stage holds the forwarded request; an
// in-order owner FIFO remembers which channel issued each accepted request
// so the matching response can be steered back with no added latency.
module mem_req_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_req_arbiter_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_found;
    logic              can_issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CH_W-1:0]   owner_mem [MAX_OUTST];
    logic [CH_W-1:0]   head;
    logic              rsp_err_q;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A slot exists when the output stage is free (or draining this cycle)
    // and the owner FIFO is not full; a same-cycle pop does not count.
    assign can_issue = (!bus.mem_req_valid || bus.mem_req_ready) && (count < MAX_CNT);
    assign push      = gnt_found;
    assign pop       = bus.mem_rsp_valid && (count != '0);
    assign head      = owner_mem[rd_ptr];

    // Round-robin search: first valid channel at or after rr_ptr wins.
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (can_issue) begin
            for (int k = 0; k < NUM_CH; k++) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!gnt_found && bus.ch_req_valid[i] &&
                        (((int'(rr_ptr) + k) % NUM_CH) == i)) begin
                        gnt_found = 1'b1;
                        gnt_idx   = CH_W'(i);
                    end
                end
            end
        end
    end

    // Payload mux: pick the granted channel's wr/addr/data.
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i)) begin
                sel_wr   = bus.ch_req_wr[i];
                sel_addr = bus.ch_req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.ch_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot accept and response steering, both forced low while in reset.
    always_comb begin
        bus.ch_req_ready = '0;
        bus.ch_rsp_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_req_ready[i] = reset && gnt_found && (gnt_idx == CH_W'(i));
            bus.ch_rsp_valid[i] = reset && pop && (head == CH_W'(i));
        end
    end

    assign bus.ch_rsp_data = bus.mem_rsp_data;
    assign bus.outstanding = count;
    assign bus.rsp_err     = rsp_err_q;

    // Output stage: load on grant, hold until the cache controller accepts.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_wr    <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_req_data  <= '0;
        end else if (push) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_wr    <= sel_wr;
            bus.mem_req_addr  <= sel_addr;
            bus.mem_req_data  <= sel_data;
        end else if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the channel that was granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Owner FIFO pointers, occupancy and the sticky orphan-response flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (bus.mem_rsp_valid && (count == '0)) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    // Owner FIFO storage.
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_mem[wr_ptr] <= gnt_idx;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a table of per-cycle vectors for the
// basic and alternating-grant traffic, then hand-written sequences for the
// outstanding limit, output stall, response routing and async reset.
module tb_mem_req_arbiter;
    localparam int NUM_CH    = 2;
    localparam int ADDR_W    = 21;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 4;

    localparam logic [ADDR_W-1:0] A0 = 21'h00010;
    localparam logic [ADDR_W-1:0] A1 = 21'h00200;
    localparam logic [DATA_W-1:0] D0 = 32'hA0A0_0000;
    localparam logic [DATA_W-1:0] D1 = 32'hB1B1_0001;

    typedef struct {
        logic [1:0]        valid;
        logic              mready;
        logic              rsp_v;
        logic [31:0]       rsp_d;
        logic [1:0]        exp_ready;
        logic [1:0]        exp_rsp;
        logic              exp_mvalid;
        logic [ADDR_W-1:0] exp_maddr;
        logic [2:0]        exp_outst;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .MAX_OUTST(MAX_OUTST)) bus ();

    mem_req_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .MAX_OUTST(MAX_OUTST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_ch(input int ch, input logic v, input logic wr,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.ch_req_valid[ch]                 = v;
        bus.ch_req_wr[ch]                    = wr;
        bus.ch_req_addr[ch*ADDR_W +: ADDR_W] = a;
        bus.ch_req_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic drive_mem(input logic rdy, input logic rv, input logic [DATA_W-1:0] rd);
        bus.mem_req_ready = rdy;
        bus.mem_rsp_valid = rv;
        bus.mem_rsp_data  = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // valid mready rsp_v rsp_d  exp_ready exp_rsp mvalid maddr outst
        vecs[0] = '{2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b0, 21'h0, 3'd0};
        vecs[1] = '{2'b00, 1'b1, 1'b1, 32'hDEADBEEF,  2'b00, 2'b01, 1'b1, A0,    3'd1};
        vecs[2] = '{2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, A0,    3'd0};
        vecs[3] = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b0, A0,    3'd0};
        vecs[4] = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, A1,    3'd1};
        vecs[5] = '{2'b11, 1'b1, 1'b1, 32'h11110001,  2'b10, 2'b10, 1'b1, A0,    3'd2};
        vecs[6] = '{2'b11, 1'b1, 1'b1, 32'h22220002,  2'b01, 2'b01, 1'b1, A1,    3'd2};
        vecs[7] = '{2'b00, 1'b1, 1'b1, 32'h33330003,  2'b00, 2'b10, 1'b1, A0,    3'd2};
        vecs[8] = '{2'b00, 1'b1, 1'b1, 32'h44440004,  2'b00, 2'b01, 1'b0, A0,    3'd1};
        vecs[9] = '{2'b00, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, A0,    3'd0};

        // Reset state
        reset = 1'b0;
        drive_ch(0, 1'b0, 1'b0, A0, D0);
        drive_ch(1, 1'b0, 1'b0, A1, D1);
        drive_mem(1'b0, 1'b0, 32'h0);
        #2;
        check("rst_mem_req_valid", bus.mem_req_valid, 0);
        check("rst_outstanding",   bus.outstanding,   0);
        check("rst_rsp_err",       bus.rsp_err,       0);
        check("rst_ch_req_ready",  bus.ch_req_ready,  0);
        check("rst_mem_req_addr",  bus.mem_req_addr,  0);
        tick();
        reset = 1'b1;

        // Table: single read + response, then alternating grants
        for (int i = 0; i < 10; i++) begin
            drive_ch(0, vecs[i].valid[0], 1'b0, A0, D0);
            drive_ch(1, vecs[i].valid[1], 1'b0, A1, D1);
            drive_mem(vecs[i].mready, vecs[i].rsp_v, vecs[i].rsp_d);
            settle();
            check($sformatf("vec%0d_ch_req_ready", i),  bus.ch_req_ready,  vecs[i].exp_ready);
            check($sformatf("vec%0d_ch_rsp_valid", i),  bus.ch_rsp_valid,  vecs[i].exp_rsp);
            check($sformatf("vec%0d_mem_req_valid", i), bus.mem_req_valid, vecs[i].exp_mvalid);
            check($sformatf("vec%0d_mem_req_addr", i),  bus.mem_req_addr,  vecs[i].exp_maddr);
            check($sformatf("vec%0d_outstanding", i),   bus.outstanding,   vecs[i].exp_outst);
            if (vecs[i].rsp_v) begin
                check($sformatf("vec%0d_ch_rsp_data", i), bus.ch_rsp_data, vecs[i].rsp_d);
            end
            tick();
        end

        // Outstanding limit: four accepts, fifth blocked until a response
        drive_ch(0, 1'b1, 1'b0, A0, D0);
        drive_ch(1, 1'b0, 1'b0, A1, D1);
        drive_mem(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("limit_accept%0d_ready", k), bus.ch_req_ready, 2'b01);
            check($sformatf("limit_accept%0d_outst", k), bus.outstanding,  k);
            tick();
        end
        settle();
        check("limit_full_ready", bus.ch_req_ready, 2'b00);
        check("limit_full_outst", bus.outstanding,  4);
        tick();
        drive_mem(1'b1, 1'b1, 32'h5555_0000);
        settle();
        check("limit_no_bypass_ready", bus.ch_req_ready, 2'b00);
        check("limit_pop_rsp_valid",   bus.ch_rsp_valid, 2'b01);
        tick();
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("limit_fifth_ready", bus.ch_req_ready, 2'b01);
        check("limit_fifth_outst", bus.outstanding,  3);
        tick();
        drive_ch(0, 1'b0, 1'b0, A0, D0);
        settle();
        check("limit_refill_outst", bus.outstanding, 4);
        drive_mem(1'b1, 1'b1, 32'h6666_0000);
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("limit_drain%0d_rsp", k), bus.ch_rsp_valid, 2'b01);
            tick();
        end
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("limit_drained_outst", bus.outstanding, 0);
        tick();

        // Output stall: ch1 write held while the cache controller is not ready
        drive_ch(1, 1'b1, 1'b1, 21'h1FFFF, 32'h12345678);
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("stall_first_ready", bus.ch_req_ready, 2'b10);
        tick();
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("stall%0d_mvalid", k), bus.mem_req_valid, 1);
            check($sformatf("stall%0d_addr", k),   bus.mem_req_addr,  21'h1FFFF);
            check($sformatf("stall%0d_data", k),   bus.mem_req_data,  32'h12345678);
            check($sformatf("stall%0d_wr", k),     bus.mem_req_wr,    1);
            check($sformatf("stall%0d_ready", k),  bus.ch_req_ready,  2'b00);
            tick();
        end
        drive_ch(1, 1'b0, 1'b0, A1, D1);
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("stall_release_outst", bus.outstanding, 1);
        tick();
        settle();
        check("stall_done_mvalid", bus.mem_req_valid, 0);
        drive_mem(1'b1, 1'b1, 32'hCAFE_0001);
        settle();
        check("stall_rsp_valid", bus.ch_rsp_valid, 2'b10);
        tick();
        drive_mem(1'b1, 1'b0, 32'h0);

        // Response routing: ch1 read then ch0 write, then an orphan response
        drive_ch(1, 1'b1, 1'b0, A1, D1);
        settle();
        check("route_ch1_ready", bus.ch_req_ready, 2'b10);
        tick();
        drive_ch(1, 1'b0, 1'b0, A1, D1);
        drive_ch(0, 1'b1, 1'b1, A0, D0);
        settle();
        check("route_ch0_ready", bus.ch_req_ready, 2'b01);
        check("route_req1_addr", bus.mem_req_addr, A1);
        check("route_req1_wr",   bus.mem_req_wr,   0);
        tick();
        drive_ch(0, 1'b0, 1'b0, A0, D0);
        settle();
        check("route_req2_addr", bus.mem_req_addr, A0);
        check("route_req2_wr",   bus.mem_req_wr,   1);
        check("route_req2_data", bus.mem_req_data, D0);
        check("route_outst",     bus.outstanding,  2);
        tick();
        drive_mem(1'b1, 1'b1, 32'h7777_0001);
        settle();
        check("route_rsp1_valid", bus.ch_rsp_valid, 2'b10);
        check("route_rsp1_data",  bus.ch_rsp_data,  32'h7777_0001);
        tick();
        drive_mem(1'b1, 1'b1, 32'h7777_0002);
        settle();
        check("route_rsp2_valid", bus.ch_rsp_valid, 2'b01);
        tick();
        drive_mem(1'b1, 1'b1, 32'h7777_0003);
        settle();
        check("orphan_rsp_valid", bus.ch_rsp_valid, 2'b00);
        check("orphan_err_before", bus.rsp_err,     0);
        tick();
        drive_mem(1'b1, 1'b0, 32'h0);
        settle();
        check("orphan_err_sticky", bus.rsp_err,     1);
        check("orphan_outst",      bus.outstanding, 0);
        tick();

        // Asynchronous reset with two requests in flight
        drive_ch(0, 1'b1, 1'b0, A0, D0);
        settle();
        check("areset_g0_ready", bus.ch_req_ready, 2'b01);
        tick();
        drive_ch(0, 1'b0, 1'b0, A0, D0);
        drive_ch(1, 1'b1, 1'b1, A1, D1);
        settle();
        check("areset_g1_ready", bus.ch_req_ready, 2'b10);
        tick();
        drive_ch(1, 1'b0, 1'b0, A1, D1);
        drive_mem(1'b0, 1'b0, 32'h0);
        settle();
        check("areset_pre_mvalid", bus.mem_req_valid, 1);
        check("areset_pre_outst",  bus.outstanding,   2);
        drive_ch(0, 1'b1, 1'b0, A0, D0);
        drive_ch(1, 1'b1, 1'b0, A1, D1);
        drive_mem(1'b1, 1'b1, 32'h8888_0000);
        #1 reset = 1'b0;
        #1;
        check("areset_mvalid",  bus.mem_req_valid, 0);
        check("areset_outst",   bus.outstanding,   0);
        check("areset_rsp_err", bus.rsp_err,       0);
        check("areset_ready",   bus.ch_req_ready,  2'b00);
        check("areset_rsp",     bus.ch_rsp_valid,  2'b00);
        check("areset_addr",    bus.mem_req_addr,  0);
        check("areset_data",    bus.mem_req_data,  0);
        check("areset_wr",      bus.mem_req_wr,    0);
        drive_mem(1'b1, 1'b0, 32'h0);
        #1 reset = 1'b1;
        #1;
        check("areset_first_grant", bus.ch_req_ready, 2'b01);
        tick();
        drive_ch(0, 1'b0, 1'b0, A0, D0);
        drive_ch(1, 1'b0, 1'b0, A1, D1);
        settle();
        check("areset_first_addr", bus.mem_req_addr, A0);
        check("areset_first_outst", bus.outstanding, 1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
